// File: rtl/arbiter_requester_pkg.sv
// Shared defaults and the aged-priority helper for the arbiter requester block.
package arbiter_requester_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_AGE_STEP = 4;
  localparam int DEF_STARVE   = 32;

  // Aged priority, summed at full width and then clamped to the top level n-1.
  function automatic int sat_prt(input int base, input int wait_ticks,
                                 input int age_step, input int n);
    int sum;
    sum = base + wait_ticks / age_step;
    return (sum > n - 1) ? n - 1 : sum;
  endfunction

endpackage

// File: rtl/requester_slot.sv
// One requester: pending-job counter, aging wait counter and sticky flags.
module requester_slot
  import arbiter_requester_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int LN       = $clog2(N),
  parameter int DEPTH    = 7,
  parameter int AGE_STEP = DEF_AGE_STEP,
  parameter int STARVE   = DEF_STARVE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          add,
  input  logic          consume,
  input  logic [LN-1:0] base_prt,
  output logic          req,
  output logic [LN-1:0] prt,
  output logic          overflow,
  output logic          starve
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(STARVE + 1);

  logic [CW-1:0] pending_q, pending_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          overflow_q, overflow_d;
  logic          starve_q, starve_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    pending_d  = pending_q;
    wait_d     = wait_q;
    overflow_d = overflow_q;
    starve_d   = starve_q;

    // A coincident add and consume cancel; consume is only ever raised while pending is non-zero.
    case ({add, consume})
      2'b01:   pending_d = pending_q - 1'b1;
      2'b10:   if (pending_q == CW'(DEPTH)) overflow_d = 1'b1;
               else                         pending_d  = pending_q + 1'b1;
      default: ;
    endcase

    if (consume || pending_q == '0) begin
      wait_d = '0;
    end else if (tick && wait_q != WW'(STARVE)) begin
      wait_d = wait_q + 1'b1;
      if (wait_q == WW'(STARVE - 1)) starve_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      pending_q  <= '0;
      wait_q     <= '0;
      overflow_q <= 1'b0;
      starve_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      wait_q     <= wait_d;
      overflow_q <= overflow_d;
      starve_q   <= starve_d;
    end
  end

  assign req      = (pending_q != '0);
  assign prt      = LN'(sat_prt(int'(base_prt), int'(wait_q), AGE_STEP, N));
  assign overflow = overflow_q;
  assign starve   = starve_q;

endmodule

// File: rtl/arbiter_requester.sv
// Requester front-end: N job queues with aging priority, grant consumption and protocol checking.
module arbiter_requester
  import arbiter_requester_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int LN       = $clog2(N),
  parameter int DEPTH    = 7,
  parameter int AGE_STEP = DEF_AGE_STEP,
  parameter int STARVE   = DEF_STARVE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [N-1:0]          add,
  input  logic [N-1:0][LN-1:0]  base_prt,
  input  logic [LN-1:0]         grant,
  input  logic                  valid,
  output logic [N-1:0]          req,
  output logic [N-1:0][LN-1:0]  prt,
  output logic [N-1:0]          overflow,
  output logic [N-1:0]          starve,
  output logic                  proto_err,
  output logic [15:0]           served_total
);

  logic [N-1:0] consume;
  logic         strobe;
  logic         bad_grant;
  logic         age_tick;

  assign strobe = clk_en & valid;

  // An out-of-range grant matches no slot, so it falls out as a bad grant naturally.
  assign bad_grant = strobe & ~(|consume);
  assign age_tick  = clk_en & ~bad_grant;

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign consume[i] = strobe & (grant == LN'(i)) & req[i];

    requester_slot #(
      .N        (N),
      .LN       (LN),
      .DEPTH    (DEPTH),
      .AGE_STEP (AGE_STEP),
      .STARVE   (STARVE)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .tick     (age_tick),
      .add      (add[i]),
      .consume  (consume[i]),
      .base_prt (base_prt[i]),
      .req      (req[i]),
      .prt      (prt[i]),
      .overflow (overflow[i]),
      .starve   (starve[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err    <= 1'b0;
      served_total <= '0;
    end else begin
      if (bad_grant) proto_err    <= 1'b1;
      if (|consume)  served_total <= served_total + 16'd1;
    end
  end

endmodule

// File: tb/tb_arbiter_requester.sv
// Self-checking bench: constant vector table, directed corner sequences and a random run,
// all cross-checked against a behavioural model through an expectation queue.
module tb_arbiter_requester;

  localparam int N        = 4;
  localparam int LN       = 2;
  localparam int DEPTH    = 7;
  localparam int AGE_STEP = 4;
  localparam int STARVE   = 32;

  logic                 clk = 1'b0;
  logic                 rst, clk_en, valid;
  logic [N-1:0]         add;
  logic [N-1:0][LN-1:0] base_prt;
  logic [LN-1:0]        grant;
  logic [N-1:0]         req, overflow, starve;
  logic [N-1:0][LN-1:0] prt;
  logic                 proto_err;
  logic [15:0]          served_total;

  always #5 clk = ~clk;

  arbiter_requester #(
    .N(N), .LN(LN), .DEPTH(DEPTH), .AGE_STEP(AGE_STEP), .STARVE(STARVE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .add          (add),
    .base_prt     (base_prt),
    .grant        (grant),
    .valid        (valid),
    .req          (req),
    .prt          (prt),
    .overflow     (overflow),
    .starve       (starve),
    .proto_err    (proto_err),
    .served_total (served_total)
  );

  typedef struct {
    logic [N-1:0]         req;
    logic [N-1:0][LN-1:0] prt;
    logic [N-1:0]         ovf;
    logic [N-1:0]         stv;
    logic                 perr;
    logic [15:0]          served;
  } exp_t;

  typedef struct {
    logic         r;
    logic [N-1:0] a;
    logic         ce;
    logic         v;
    logic [1:0]   g;
    logic [N-1:0] req;
    logic [15:0]  served;
    logic         perr;
  } vec_t;

  exp_t  sb_q[$];
  vec_t  vecs[11];

  int       m_pend[N];
  int       m_wait[N];
  bit [N-1:0] m_ovf, m_stv;
  bit       m_perr;
  int       m_served;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s @%0t: got %0h, expected %0h", phase, name, $time, act, exp);
    end
  endtask

  // Behavioural reference: one clock edge of the requester front-end.
  task automatic model_step();
    int  c, p;
    bit  bad;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_wait[i] = 0; end
      m_ovf = '0; m_stv = '0; m_perr = 0; m_served = 0;
    end else begin
      c = -1;
      bad = 0;
      if (clk_en && valid) begin
        if (int'(grant) < N && m_pend[grant] > 0) c = int'(grant);
        else begin bad = 1; m_perr = 1; end
      end
      for (int i = 0; i < N; i++) begin
        p = m_pend[i] + int'(add[i]) - ((c == i) ? 1 : 0);
        if (p > DEPTH) begin p = DEPTH; m_ovf[i] = 1; end
        if (c == i) m_wait[i] = 0;
        else if (clk_en && !bad && m_pend[i] > 0 && m_wait[i] < STARVE) begin
          m_wait[i]++;
          if (m_wait[i] == STARVE) m_stv[i] = 1;
        end
        m_pend[i] = p;
      end
      if (c >= 0) m_served = (m_served + 1) % 65536;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   pr;
    for (int i = 0; i < N; i++) begin
      e.req[i] = (m_pend[i] > 0);
      pr = int'(base_prt[i]) + m_wait[i] / AGE_STEP;
      if (pr > N - 1) pr = N - 1;
      e.prt[i] = LN'(pr);
    end
    e.ovf    = m_ovf;
    e.stv    = m_stv;
    e.perr   = m_perr;
    e.served = 16'(m_served);
    return e;
  endfunction

  task automatic cycle(input logic r, input logic [N-1:0] a, input logic ce,
                       input logic v, input logic [1:0] g);
    exp_t e;
    @(negedge clk);
    rst = r; add = a; clk_en = ce; valid = v; grant = g;
    model_step();
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("req",          32'(req),          32'(e.req));
    check("prt",          32'(prt),          32'(e.prt));
    check("overflow",     32'(overflow),     32'(e.ovf));
    check("starve",       32'(starve),       32'(e.stv));
    check("proto_err",    32'(proto_err),    32'(e.perr));
    check("served_total", 32'(served_total), 32'(e.served));
  endtask

  initial begin
    rst = 1'b1; add = '0; clk_en = 1'b0; valid = 1'b0; grant = '0;
    base_prt = {2'd2, 2'd0, 2'd1, 2'd0};

    //            rst add   ce v  g     req    served perr
    vecs[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 4'h1, 16'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 4'h1, 16'd0, 1'b0};
    vecs[3]  = '{1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 4'h1, 16'd0, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 16'd1, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 4'h1, 16'd1, 1'b0};
    vecs[6]  = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 16'd2, 1'b0};
    vecs[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 4'h0, 16'd3, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 4'h0, 16'd3, 1'b1};
    vecs[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 16'd3, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 16'd0, 1'b0};

    phase = "table";
    for (int k = 0; k < 11; k++) begin
      cycle(vecs[k].r, vecs[k].a, vecs[k].ce, vecs[k].v, vecs[k].g);
      check("vec_req",    32'(req),          32'(vecs[k].req));
      check("vec_served", 32'(served_total), 32'(vecs[k].served));
      check("vec_perr",   32'(proto_err),    32'(vecs[k].perr));
      if (k == 0) check("rst_prt", 32'(prt), 32'h84);
    end

    // Queue fills to DEPTH, the 8th add overflows, then drains in exactly 7 grants.
    phase = "overflow";
    cycle(1, '0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 4'b0010, 0, 0, 0);
      if (k == 6) check("ovf_before", 32'(overflow[1]), 32'd0);
      if (k == 7) check("ovf_after",  32'(overflow[1]), 32'd1);
    end
    for (int k = 0; k < 7; k++) begin
      cycle(0, '0, 1, 1, 2'd1);
      if (k == 5) check("req1_held", 32'(req[1]), 32'd1);
    end
    check("req1_drained", 32'(req[1]),      32'd0);
    check("served7",      32'(served_total), 32'd7);
    check("ovf_sticky",   32'(overflow[1]),  32'd1);

    // Add coincident with consume at a full queue, then reset beating add and grant.
    phase = "add_consume";
    cycle(1, '0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cycle(0, 4'b0001, 0, 0, 0);
    cycle(0, 4'b0001, 1, 1, 2'd0);
    check("ovf0_clear", 32'(overflow[0]), 32'd0);
    cycle(0, 4'b0001, 0, 0, 0);
    check("ovf0_full",  32'(overflow[0]), 32'd1);
    cycle(1, 4'hF, 1, 1, 2'd0);
    check("rst_req",    32'(req), 32'd0);

    // Aging on requester 2 from base 0: steps at ticks 4, 8, 12, then saturates.
    phase = "aging";
    cycle(0, 4'b0100, 0, 0, 0);
    for (int t = 1; t <= 16; t++) begin
      cycle(0, '0, 1, 0, 0);
      check("prt2_age", 32'(prt[2]), (t < 4) ? 32'd0 : (t < 8) ? 32'd1 : (t < 12) ? 32'd2 : 32'd3);
    end
    cycle(0, '0, 1, 1, 2'd2);
    check("prt2_reset", 32'(prt[2]), 32'd0);
    check("req2_done",  32'(req[2]), 32'd0);

    // Starvation flag on requester 3 at 32 ticks, sticky across a later grant.
    phase = "starve";
    cycle(1, '0, 0, 0, 0);
    cycle(0, 4'b1000, 0, 0, 0);
    cycle(0, 4'b1000, 0, 0, 0);
    for (int t = 1; t <= 40; t++) begin
      cycle(0, '0, 1, 0, 0);
      if (t == 31) check("stv3_early", 32'(starve[3]), 32'd0);
      if (t == 32) check("stv3_set",   32'(starve[3]), 32'd1);
    end
    cycle(0, '0, 1, 1, 2'd3);
    check("stv3_sticky", 32'(starve[3]), 32'd1);
    check("prt3_base",   32'(prt[3]),    32'd2);

    phase = "random";
    cycle(1, '0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 59) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom), 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arbiter_requester.md
ARBITER_REQUESTER -- requirements
Module: arbiter_requester

Interface
REQ-001 Parameter N, default 4: number of requesters.
REQ-002 Parameter LN, default $clog2(N): width of grant and priority fields.
REQ-003 Parameter DEPTH, default 7: maximum pending jobs per requester; counter width $clog2(DEPTH+1).
REQ-004 Parameter AGE_STEP, default 4: arbitration ticks of waiting per one-level priority boost.
REQ-005 Parameter STARVE, default 32: waiting ticks at which a requester is flagged starved.
REQ-006 clk  in  1  clock; reset rst, synchronous, active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 clk_en  in  1  arbitration tick, the same strobe that drives the arbiter.
REQ-009 add  in  N  per-requester one-cycle pulse enqueuing one job.
REQ-010 base_prt  in  LN x N  static base priority per requester.
REQ-011 grant  in  LN  arbiter winner index.
REQ-012 valid  in  1  arbiter grant valid.
REQ-013 req  out  N  request vector to the arbiter.
REQ-014 prt  out  LN x N  effective (aged) priority per requester.
REQ-015 overflow  out  N  sticky: job dropped because the queue was full.
REQ-016 starve  out  N  sticky: wait reached STARVE ticks.
REQ-017 proto_err  out  1  sticky: grant to a non-requesting index.
REQ-018 served_total  out  16  count of consumed grants, wraps at 2^16.

Function
REQ-019 req[i] SHALL be pending[i] != 0, decoded from registers with no combinational path from add, grant or valid.
REQ-020 A grant SHALL be consumed only on a cycle with clk_en=1, valid=1 and req[grant]=1; pending[grant] decrements by 1 and served_total increments by 1.
REQ-021 add[i]=1 SHALL increment pending[i] on any cycle, independent of clk_en.
REQ-022 Simultaneous add[i] and consumed grant to i SHALL leave pending[i] unchanged and SHALL NOT set overflow[i].
REQ-023 add[i] with pending[i]=DEPTH and no concurrent consume SHALL drop the job, hold pending[i] at DEPTH and set overflow[i].
REQ-024 wait[i] (saturating at STARVE) SHALL increment on clk_en when req[i]=1 and i is not consumed-granted, and SHALL clear on consume to i or when pending[i] reaches 0.
REQ-025 prt[i] SHALL be min(base_prt[i] + wait[i]/AGE_STEP, N-1), computed at full width before saturating, and registered or derived from registers only.
REQ-026 starve[i] SHALL set on the cycle wait[i] becomes STARVE.
REQ-027 clk_en=1, valid=1 and req[grant]=0 SHALL set proto_err and change no pending, wait or served_total state.
REQ-028 valid=0, or clk_en=0, SHALL leave pending (apart from adds), wait and served_total unchanged.
REQ-029 grant >= N with valid=1 and clk_en=1 SHALL be treated as a non-requesting index (REQ-027).

Reset
REQ-030 rst SHALL clear pending, wait, overflow, starve, proto_err and served_total, so req=0, and SHALL drive prt=base_prt.
REQ-031 rst SHALL take priority over add and grant on the same cycle, and a reset mid-wait SHALL discard all queued jobs.

Structure
REQ-032 A shared package SHALL hold default N, the AGE_STEP and STARVE constants, and a function computing the saturated priority.
REQ-033 One sub-module, requester_slot, SHALL hold a single requester's pending, wait and sticky flags; the top SHALL instantiate N slots and add the grant decode, proto_err and served_total.

Verification
REQ-034 Scenario: add[0] for 3 cycles, then valid=1, grant=0 on 3 clk_en ticks -> pending 3,2,1,0; req[0] falls after the third tick; served_total=3.
REQ-035 Scenario: 8 add[1] pulses with DEPTH=7 -> pending[1]=7 and overflow[1]=1 from the 8th pulse onward.
REQ-036 Scenario: base_prt[2]=0, req[2] held, no grant for 12 ticks -> prt[2] steps 0,1,2,3 at ticks 4, 8 and 12, then saturates at 3; a consume returns it to 0.
REQ-037 Scenario: requester 3 waits 32 ticks -> starve[3]=1 at tick 32 and stays 1 after it is later granted.
REQ-038 Scenario: valid=1, grant=1 with pending[1]=0 -> proto_err=1; served_total and all pending values unchanged.
REQ-039 Scenario: add[0] coincident with consume of 0 at pending[0]=7 -> pending stays 7 and overflow[0]=0; then rst with jobs queued -> req=0 on the next cycle.
